mem_access_ctrl: RTL and testbench

Multi-cycle memory access sequencer sitting directly upstream of the memory interface wrapper. Accepts instruction-fetch, load and store requests from the control unit, drives the memory interface address, data, read and write lines for a bounded access window, waits out the synchronous ROM/RAM latency, and captures returned data into IR or MDR. Unassigned addresses, writes to the ROM region and missing MFC are reported as faults, so the control unit never stalls indefinitely.

---
 rtl/mem_access_ctrl_pkg.sv | 28 ++
 rtl/mem_access_ctrl_if.sv | 37 +++
 rtl/mem_access_ctrl_wait_timer.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the memory access sequencer: FSM states, access ops
// and fault codes. The control unit decodes the same constants.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_FETCH = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ANA     = 2'b01;
    localparam logic [1:0] FC_ROM     = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;

    // True when a word address falls inside the read-only region.
    function automatic logic in_rom(input logic [31:0] addr, input logic [31:0] rom_top);
        return (addr <= rom_top);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/capture bus between the control unit and the sequencer, plus the
// memory interface wrapper lines the sequencer drives and observes.
interface mem_access_ctrl_if;
    logic        fetch_req;
    logic        load_req;
    logic        store_req;
    logic [31:0] pc;
    logic [31:0] rz;
    logic [31:0] rm;
    logic [31:0] mem_data_out;
    logic        mem_mfc;
    logic        mem_ana_flag;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;

    modport master (
        output fetch_req, load_req, store_req, pc, rz, rm,
               mem_data_out, mem_mfc, mem_ana_flag,
        input  mem_address, mem_data_in, mem_read, mem_write,
               ir, mdr, busy, done, fault, fault_code
    );

    modport slave (
        input  fetch_req, load_req, store_req, pc, rz, rm,
               mem_data_out, mem_mfc, mem_ana_flag,
        output mem_address, mem_data_in, mem_read, mem_write,
               ir, mdr, busy, done, fault, fault_code
    );
endinterface

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait/timeout counter pair: counts down the fixed memory latency, then
// counts cycles spent waiting for MFC, saturating at the timeout limit.
module mac_wait_timer #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned TIMEOUT     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic step,
    output logic wait_zero,
    output logic expired
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    logic [3:0] wait_cnt_r;
    logic [7:0] tmo_cnt_r;

    // Counter pair: reload on acceptance, otherwise drain wait then count timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
            tmo_cnt_r  <= 8'd0;
        end else if (load) begin
            wait_cnt_r <= WAIT_INIT;
            tmo_cnt_r  <= 8'd0;
        end else if (step) begin
            if (wait_cnt_r != 4'd0) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end else if (tmo_cnt_r != TMO_LIMIT) begin
                tmo_cnt_r <= tmo_cnt_r + 8'd1;
            end else begin
                tmo_cnt_r <= tmo_cnt_r;
            end
        end else begin
            wait_cnt_r <= wait_cnt_r;
            tmo_cnt_r  <= tmo_cnt_r;
        end
    end

    assign wait_zero = (wait_cnt_r == 4'd0);
    assign expired   = (tmo_cnt_r == TMO_LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access sequencer: serves fetch/load/store requests over a
// bounded access window and reports ANA, ROM-write and MFC-timeout faults.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned TIMEOUT     = 8,
    parameter logic [31:0] ROM_TOP     = 32'h0000_003F
) (
    input  logic            clk,
    input  logic            rst,
    mem_access_ctrl_if.slave bus
);
    state_t      state_r, state_next_s;
    op_t         op_r, op_next_s;
    logic        accept_s;
    logic [31:0] addr_r, addr_next_s;
    logic [31:0] wdata_r, wdata_next_s;
    logic [1:0]  fault_code_r, fault_code_next_s;
    logic        capture_ir_s, capture_mdr_s;
    logic [31:0] ir_r, mdr_r;
    logic        mem_read_r, mem_write_r;
    logic        busy_r, done_r, fault_r;
    logic        wait_zero_s, expired_s, timer_step_s;

    mac_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .TIMEOUT     (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .step      (timer_step_s),
        .wait_zero (wait_zero_s),
        .expired   (expired_s)
    );

    assign timer_step_s = (state_r == ST_ACCESS);

    // Next-state, request arbitration (Store > Load > Fetch) and capture decode.
    always_comb begin
        state_next_s      = state_r;
        op_next_s         = op_r;
        accept_s          = 1'b0;
        addr_next_s       = addr_r;
        wdata_next_s      = wdata_r;
        fault_code_next_s = fault_code_r;
        capture_ir_s      = 1'b0;
        capture_mdr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.store_req) begin
                    accept_s  = 1'b1;
                    op_next_s = OP_STORE;
                end else if (bus.load_req) begin
                    accept_s  = 1'b1;
                    op_next_s = OP_LOAD;
                end else if (bus.fetch_req) begin
                    accept_s  = 1'b1;
                    op_next_s = OP_FETCH;
                end else begin
                    accept_s  = 1'b0;
                end
                if (accept_s) begin
                    addr_next_s       = (op_next_s == OP_FETCH) ? bus.pc : bus.rz;
                    wdata_next_s      = (op_next_s == OP_STORE) ? bus.rm : wdata_r;
                    fault_code_next_s = FC_NONE;
                    // ROM stores are rejected before any strobe is raised.
                    if ((op_next_s == OP_STORE) && in_rom(bus.rz, ROM_TOP)) begin
                        state_next_s      = ST_FAULT;
                        fault_code_next_s = FC_ROM;
                    end else begin
                        state_next_s = ST_ACCESS;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!wait_zero_s) begin
                    state_next_s = ST_ACCESS;
                end else if (bus.mem_ana_flag) begin
                    state_next_s      = ST_FAULT;
                    fault_code_next_s = FC_ANA;
                end else if (bus.mem_mfc) begin
                    state_next_s  = ST_DONE;
                    capture_ir_s  = (op_r == OP_FETCH);
                    capture_mdr_s = (op_r == OP_LOAD);
                end else if (expired_s) begin
                    state_next_s      = ST_FAULT;
                    fault_code_next_s = FC_TIMEOUT;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            ST_FAULT: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State, latched bus, capture registers and registered status/strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_FETCH;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            fault_code_r <= FC_NONE;
            ir_r         <= 32'd0;
            mdr_r        <= 32'd0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fault_r      <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            op_r         <= op_next_s;
            addr_r       <= addr_next_s;
            wdata_r      <= wdata_next_s;
            fault_code_r <= fault_code_next_s;
            ir_r         <= capture_ir_s  ? bus.mem_data_out : ir_r;
            mdr_r        <= capture_mdr_s ? bus.mem_data_out : mdr_r;
            mem_read_r   <= (state_next_s == ST_ACCESS) && (op_next_s != OP_STORE);
            mem_write_r  <= (state_next_s == ST_ACCESS) && (op_next_s == OP_STORE);
            busy_r       <= (state_next_s != ST_IDLE);
            done_r       <= (state_next_s == ST_DONE);
            fault_r      <= (state_next_s == ST_FAULT);
        end
    end

    assign bus.mem_address = addr_r;
    assign bus.mem_data_in = wdata_r;
    assign bus.mem_read    = mem_read_r;
    assign bus.mem_write   = mem_write_r;
    assign bus.ir          = ir_r;
    assign bus.mdr         = mdr_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.fault       = fault_r;
    assign bus.fault_code  = fault_code_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized bench for mem_access_ctrl with a transaction-level
// reference model (outcome, latency and captured data per access).
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int          W       = 1;
    localparam int          T       = 8;
    localparam logic [31:0] ROM_TOP = 32'h0000_003F;

    logic clk = 1'b0;
    logic rst;
    mem_access_ctrl_if bus();

    mem_access_ctrl #(.WAIT_CYCLES(W), .TIMEOUT(T), .ROM_TOP(ROM_TOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ir_exp   = 32'd0;
    logic [31:0] mdr_exp  = 32'd0;
    logic [1:0]  code_exp = 2'b00;
    logic [31:0] mem [logic [31:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // op: 0 fetch, 1 load, 2 store; d: cycles MFC lags behind the wait window.
    task automatic run_txn(input int op, input logic [31:0] addr, input logic [31:0] data,
                           input bit ana, input int d);
        int          e;
        bit          ok;
        bit          rom;
        bit          acc;
        logic [1:0]  code;
        logic [31:0] rd;
        rom = (op == 2) && (addr <= ROM_TOP);
        if (rom) begin
            e = 1; ok = 1'b0; code = 2'b10;
        end else if (ana) begin
            e = 2 + W; ok = 1'b0; code = 2'b01;
        end else if (d <= T) begin
            e = 2 + W + d; ok = 1'b1; code = 2'b00;
        end else begin
            e = 2 + W + T; ok = 1'b0; code = 2'b11;
        end
        rd = mem.exists(addr) ? mem[addr] : (32'h0BAD_0000 ^ addr);
        if (op == 0) begin
            bus.pc = addr; bus.fetch_req = 1'b1;
        end else if (op == 1) begin
            bus.rz = addr; bus.load_req = 1'b1;
        end else begin
            bus.rz = addr; bus.rm = data; bus.store_req = 1'b1;
        end
        bus.mem_data_out = rd;
        bus.mem_ana_flag = ana;
        bus.mem_mfc      = 1'b0;
        for (int k = 1; k <= e + 1; k++) begin
            tick();
            bus.mem_mfc = (k >= 1 + W + d);
            if (k == e) begin
                if (op == 0) bus.fetch_req = 1'b0;
                else if (op == 1) bus.load_req = 1'b0;
                else bus.store_req = 1'b0;
                if (ok) begin
                    if (op == 0) ir_exp = rd;
                    else if (op == 1) mdr_exp = rd;
                    else mem[addr] = data;
                end
                code_exp = code;
            end
            acc = (k < e) && !rom;
            chk("busy",  {31'd0, bus.busy},      {31'd0, k <= e});
            chk("done",  {31'd0, bus.done},      {31'd0, (k == e) && ok});
            chk("fault", {31'd0, bus.fault},     {31'd0, (k == e) && !ok});
            chk("read",  {31'd0, bus.mem_read},  {31'd0, acc && (op != 2)});
            chk("write", {31'd0, bus.mem_write}, {31'd0, acc && (op == 2)});
            chk("code",  {30'd0, bus.fault_code}, {30'd0, (k >= e) ? code : 2'b00});
            chk("ir",    bus.ir,  ir_exp);
            chk("mdr",   bus.mdr, mdr_exp);
            if (acc) begin
                chk("addr", bus.mem_address, addr);
                if (op == 2) chk("wdata", bus.mem_data_in, data);
            end
        end
        bus.mem_mfc      = 1'b0;
        bus.mem_ana_flag = 1'b0;
    endtask

    task automatic check_reset_values();
        chk("rst_addr",  bus.mem_address, 32'd0);
        chk("rst_wdata", bus.mem_data_in, 32'd0);
        chk("rst_ir",    bus.ir,  32'd0);
        chk("rst_mdr",   bus.mdr, 32'd0);
        chk("rst_strb",  {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk("rst_stat",  {29'd0, bus.busy, bus.done, bus.fault}, 32'd0);
        chk("rst_code",  {30'd0, bus.fault_code}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.fetch_req = 1'b0; bus.load_req = 1'b0; bus.store_req = 1'b0;
        bus.pc = 32'd0; bus.rz = 32'd0; bus.rm = 32'd0;
        bus.mem_data_out = 32'd0; bus.mem_mfc = 1'b0; bus.mem_ana_flag = 1'b0;
        mem[32'h0000_0004] = 32'h1234_5678;
        tick(); tick();
        check_reset_values();
        rst = 1'b0;
        tick();

        // Directed scenarios.
        run_txn(0, 32'h0000_0004, 32'd0, 1'b0, 0);
        chk("fetch_ir", bus.ir, 32'h1234_5678);
        run_txn(2, 32'h0000_0041, 32'hDEAD_BEEF, 1'b0, 0);
        run_txn(1, 32'h0000_0041, 32'd0, 1'b0, 0);
        chk("load_mdr", bus.mdr, 32'hDEAD_BEEF);
        chk("ir_kept",  bus.ir,  32'h1234_5678);
        run_txn(2, 32'h0000_0010, 32'hCAFE_F00D, 1'b0, 0);
        run_txn(1, 32'h0000_0100, 32'd0, 1'b1, 0);
        run_txn(0, 32'h0000_0004, 32'd0, 1'b0, 0);
        run_txn(2, 32'h0000_003F, 32'h1111_2222, 1'b0, 0);
        run_txn(2, 32'h0000_0040, 32'h3333_4444, 1'b0, 0);
        run_txn(0, 32'h0000_0008, 32'd0, 1'b0, 20);
        run_txn(1, 32'h0000_0040, 32'd0, 1'b0, T);
        run_txn(1, 32'h0000_0040, 32'd0, 1'b0, T + 1);

        // All three requests together: store, then load, then fetch.
        bus.fetch_req = 1'b1; bus.load_req = 1'b1; bus.store_req = 1'b1;
        bus.pc = 32'h0000_0004;
        run_txn(2, 32'h0000_0050, 32'h5A5A_A5A5, 1'b0, 0);
        run_txn(1, 32'h0000_0050, 32'd0, 1'b0, 0);
        chk("prio_mdr", bus.mdr, 32'h5A5A_A5A5);
        run_txn(0, 32'h0000_0004, 32'd0, 1'b0, 0);

        // Reset while a store is in its access window.
        bus.rz = 32'h0000_0041; bus.rm = 32'h7777_8888; bus.store_req = 1'b1;
        bus.mem_mfc = 1'b1;
        tick();
        chk("pre_rst_write", {31'd0, bus.mem_write}, 32'd1);
        rst = 1'b1;
        tick();
        check_reset_values();
        bus.store_req = 1'b0; bus.mem_mfc = 1'b0;
        rst = 1'b0;
        ir_exp = 32'd0; mdr_exp = 32'd0; code_exp = 2'b00;
        tick();
        chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);

        // Randomized transactions across ROM, RAM and unassigned regions.
        for (int i = 0; i < 60; i++) begin
            int          op;
            int          region;
            logic [31:0] a;
            op     = int'($urandom_range(0, 2));
            region = int'($urandom_range(0, 3));
            if (region == 0)      a = 32'($urandom_range(0, 63));
            else if (region == 3) a = 32'h0000_0100 + 32'($urandom_range(0, 255));
            else                  a = 32'h0000_0040 + 32'($urandom_range(0, 15));
            run_txn(op, a, $urandom, region == 3, int'($urandom_range(0, 10)));
            chk("held_code", {30'd0, bus.fault_code}, {30'd0, code_exp});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
